// File: rtl/aes_gcm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_gcm_pkg
// Purpose  : Block type, feeder FSM encoding and the GCM inc32 helper.
// Revision : 1.0 - initial release
// ============================================================================
package aes_gcm_pkg;

   // Bit 0 is the most significant bit, matching the GCM bit-string notation.
   typedef logic [0:127] block_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AAD  = 2'd1,
      ST_PT   = 2'd2
   } feeder_state_t;

   // log2 of the block size in bits; turns a block count into a bit length.
   localparam int c_BLK_LOG2 = 7;

   // Increment the rightmost 32 bits modulo 2^32; bits [0:95] pass through.
   function automatic block_t fn_inc32(input block_t i_blk);
      block_t w_res;
      w_res          = i_blk;
      w_res[96:127]  = i_blk[96:127] + 32'd1;
      return w_res;
   endfunction

endpackage : aes_gcm_pkg
`default_nettype wire

// File: rtl/aes_gcm_instance_feeder.sv
`default_nettype none
// ============================================================================
// Module   : aes_gcm_instance_feeder
// Purpose  : Turns one instance header plus its AAD/PT block stream into
//            registered pipeline beats for the AES-GCM encrypt stages.
// Revision : 1.0 - initial release
// ============================================================================
module aes_gcm_instance_feeder
   import aes_gcm_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_hdr_valid,
   output logic             o_hdr_ready,
   input  logic [0:127]     i_j0,
   input  logic [LEN_W-1:0] i_aad_blocks,
   input  logic [LEN_W-1:0] i_pt_blocks,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   input  logic [0:127]     i_data,
   output logic             o_valid,
   output logic [0:127]     o_plain_text,
   output logic [0:127]     o_aad,
   output logic [0:127]     o_j0,
   output logic [0:127]     o_cb,
   output logic [0:127]     o_instance_size,
   output logic             o_new_instance,
   output logic             o_pt_instance,
   output logic             o_last
);

   feeder_state_t    r_state;
   block_t           r_j0;
   block_t           r_cb;
   block_t           r_size;
   logic [LEN_W-1:0] r_aad_cnt;
   logic [LEN_W-1:0] r_pt_cnt;
   logic             r_first;

   logic             w_hdr_acc;
   logic             w_data_acc;
   logic             w_aad_last;
   logic             w_pt_last;
   logic             w_pt_none;
   logic [63:0]      w_len_a;
   logic [63:0]      w_len_c;
   block_t           w_hdr_size;
   block_t           w_hdr_cb;

   // Handshake readiness depends on state alone so it never loops back on valid.
   assign o_hdr_ready  = (r_state == ST_IDLE);
   assign o_data_ready = (r_state == ST_AAD) || (r_state == ST_PT);

   assign w_hdr_acc  = i_hdr_valid  && o_hdr_ready;
   assign w_data_acc = i_data_valid && o_data_ready;

   assign w_aad_last = (r_aad_cnt == LEN_W'(1));
   assign w_pt_last  = (r_pt_cnt  == LEN_W'(1));
   assign w_pt_none  = (r_pt_cnt  == '0);

   assign w_len_a    = 64'(i_aad_blocks) << c_BLK_LOG2;
   assign w_len_c    = 64'(i_pt_blocks)  << c_BLK_LOG2;
   assign w_hdr_size = {w_len_a, w_len_c};
   assign w_hdr_cb   = fn_inc32(i_j0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_j0            <= '0;
         r_cb            <= '0;
         r_size          <= '0;
         r_aad_cnt       <= '0;
         r_pt_cnt        <= '0;
         r_first         <= 1'b0;
         o_valid         <= 1'b0;
         o_plain_text    <= '0;
         o_aad           <= '0;
         o_j0            <= '0;
         o_cb            <= '0;
         o_instance_size <= '0;
         o_new_instance  <= 1'b0;
         o_pt_instance   <= 1'b0;
         o_last          <= 1'b0;
      end else begin
         // Beat fields other than o_valid hold whenever no beat is produced.
         o_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hdr_acc) begin
                  r_j0      <= i_j0;
                  r_cb      <= w_hdr_cb;
                  r_size    <= w_hdr_size;
                  r_aad_cnt <= i_aad_blocks;
                  r_pt_cnt  <= i_pt_blocks;
                  r_first   <= 1'b1;
                  if (i_aad_blocks != '0) begin
                     r_state <= ST_AAD;
                  end else if (i_pt_blocks != '0) begin
                     r_state <= ST_PT;
                  end else begin
                     // Empty instance: a single marker beat, no data phase.
                     r_first         <= 1'b0;
                     o_valid         <= 1'b1;
                     o_plain_text    <= '0;
                     o_aad           <= '0;
                     o_j0            <= i_j0;
                     o_cb            <= w_hdr_cb;
                     o_instance_size <= w_hdr_size;
                     o_new_instance  <= 1'b1;
                     o_pt_instance   <= 1'b0;
                     o_last          <= 1'b1;
                  end
               end
            end
            ST_AAD: begin
               if (w_data_acc) begin
                  o_valid         <= 1'b1;
                  o_plain_text    <= '0;
                  o_aad           <= i_data;
                  o_j0            <= r_j0;
                  o_cb            <= r_cb;
                  o_instance_size <= r_size;
                  o_new_instance  <= r_first;
                  o_pt_instance   <= 1'b0;
                  o_last          <= w_aad_last && w_pt_none;
                  r_first         <= 1'b0;
                  r_aad_cnt       <= r_aad_cnt - LEN_W'(1);
                  if (w_aad_last) begin
                     r_state <= w_pt_none ? ST_IDLE : ST_PT;
                  end
               end
            end
            ST_PT: begin
               if (w_data_acc) begin
                  o_valid         <= 1'b1;
                  o_plain_text    <= i_data;
                  o_aad           <= '0;
                  o_j0            <= r_j0;
                  o_cb            <= r_cb;
                  o_instance_size <= r_size;
                  o_new_instance  <= r_first;
                  o_pt_instance   <= 1'b1;
                  o_last          <= w_pt_last;
                  r_first         <= 1'b0;
                  r_cb            <= fn_inc32(r_cb);
                  r_pt_cnt        <= r_pt_cnt - LEN_W'(1);
                  if (w_pt_last) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : aes_gcm_instance_feeder
`default_nettype wire

// File: tb/tb_aes_gcm_instance_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_gcm_instance_feeder
// Purpose  : Directed self-checking bench for aes_gcm_instance_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_gcm_instance_feeder;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             i_hdr_valid = 1'b0;
   logic             o_hdr_ready;
   logic [0:127]     i_j0 = '0;
   logic [LEN_W-1:0] i_aad_blocks = '0;
   logic [LEN_W-1:0] i_pt_blocks = '0;
   logic             i_data_valid = 1'b0;
   logic             o_data_ready;
   logic [0:127]     i_data = '0;
   logic             o_valid;
   logic [0:127]     o_plain_text;
   logic [0:127]     o_aad;
   logic [0:127]     o_j0;
   logic [0:127]     o_cb;
   logic [0:127]     o_instance_size;
   logic             o_new_instance;
   logic             o_pt_instance;
   logic             o_last;

   int n_cmp = 0;
   int n_err = 0;

   aes_gcm_instance_feeder #(.LEN_W(LEN_W)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_hdr_valid     (i_hdr_valid),
      .o_hdr_ready     (o_hdr_ready),
      .i_j0            (i_j0),
      .i_aad_blocks    (i_aad_blocks),
      .i_pt_blocks     (i_pt_blocks),
      .i_data_valid    (i_data_valid),
      .o_data_ready    (o_data_ready),
      .i_data          (i_data),
      .o_valid         (o_valid),
      .o_plain_text    (o_plain_text),
      .o_aad           (o_aad),
      .o_j0            (o_j0),
      .o_cb            (o_cb),
      .o_instance_size (o_instance_size),
      .o_new_instance  (o_new_instance),
      .o_pt_instance   (o_pt_instance),
      .o_last          (o_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // flags = {o_valid, o_new_instance, o_pt_instance, o_last}
   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         i_hdr_valid  = 1'($urandom);
         i_data_valid = 1'($urandom);
         i_j0         = {$urandom, $urandom, $urandom, $urandom};
         i_data       = {$urandom, $urandom, $urandom, $urandom};
         i_aad_blocks = 16'($urandom);
         i_pt_blocks  = 16'($urandom);
         n_cmp++;
         if ({o_valid, o_new_instance, o_pt_instance, o_last, o_hdr_ready, o_data_ready} !== 6'b000010) begin
            n_err++;
            $display("FAIL reset_ctrl[%0d]: got %b want 000010", i,
                     {o_valid, o_new_instance, o_pt_instance, o_last, o_hdr_ready, o_data_ready});
         end
         n_cmp++;
         if ({o_plain_text, o_aad, o_j0, o_cb, o_instance_size} !== 640'd0) begin
            n_err++;
            $display("FAIL reset_data[%0d]: beat data fields not zero", i);
         end
      end
      rst_n        = 1'b1;
      i_hdr_valid  = 1'b0;
      i_data_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_valid, o_hdr_ready, o_data_ready} !== 3'b010) begin
         n_err++;
         $display("FAIL reset_release: got %b want 010", {o_valid, o_hdr_ready, o_data_ready});
      end
   endtask

   task automatic test_basic();
      logic [0:127] j0, a0, p0, p1, size;
      j0   = 128'hCAFEBABE_DEADBEEF_01234567_00000001;
      a0   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      p0   = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
      p1   = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
      size = {64'h80, 64'h100};
      i_j0 = j0; i_aad_blocks = 16'd1; i_pt_blocks = 16'd2; i_hdr_valid = 1'b1;
      tick();
      i_hdr_valid = 1'b0;
      n_cmp++;
      if ({o_hdr_ready, o_data_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL basic_ready: got %b want 01", {o_hdr_ready, o_data_ready});
      end
      i_data_valid = 1'b1; i_data = a0;
      tick();
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1100 || o_aad !== a0 || o_plain_text !== '0) begin
         n_err++;
         $display("FAIL basic_aad_beat: flags=%b aad=%h pt=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_aad, o_plain_text);
      end
      n_cmp++;
      if (o_cb !== 128'hCAFEBABE_DEADBEEF_01234567_00000002 || o_j0 !== j0 || o_instance_size !== size) begin
         n_err++;
         $display("FAIL basic_aad_fields: cb=%h j0=%h size=%h want cb=..00000002 size=%h", o_cb, o_j0, o_instance_size, size);
      end
      i_data = p0;
      tick();
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1010 || o_plain_text !== p0 || o_aad !== '0 ||
          o_cb !== 128'hCAFEBABE_DEADBEEF_01234567_00000002) begin
         n_err++;
         $display("FAIL basic_pt0: flags=%b pt=%h aad=%h cb=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_plain_text, o_aad, o_cb);
      end
      i_data = p1;
      tick();
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1011 || o_plain_text !== p1 ||
          o_cb !== 128'hCAFEBABE_DEADBEEF_01234567_00000003 || o_instance_size !== size) begin
         n_err++;
         $display("FAIL basic_pt1: flags=%b pt=%h cb=%h size=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_plain_text, o_cb, o_instance_size);
      end
      i_data_valid = 1'b0;
      n_cmp++;
      if ({o_hdr_ready, o_data_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL basic_idle: got %b want 10", {o_hdr_ready, o_data_ready});
      end
      tick();
      n_cmp++;
      if (o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_bubble: o_valid=%b want 0", o_valid);
      end
   endtask

   task automatic test_wrap();
      logic [0:127] exp_cb [3];
      exp_cb[0] = 128'h01234567_89ABCDEF_01234567_FFFFFFFF;
      exp_cb[1] = 128'h01234567_89ABCDEF_01234567_00000000;
      exp_cb[2] = 128'h01234567_89ABCDEF_01234567_00000001;
      i_j0 = 128'h01234567_89ABCDEF_01234567_FFFFFFFE;
      i_aad_blocks = 16'd0; i_pt_blocks = 16'd3; i_hdr_valid = 1'b1;
      tick();
      i_hdr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_data_valid = 1'b1;
         i_data = {32'hA0A0A0A0, 64'd0, 32'(i)};
         tick();
         n_cmp++;
         if (o_cb !== exp_cb[i] || o_j0[0:95] !== 96'h01234567_89ABCDEF_01234567 ||
             {o_valid, o_new_instance, o_pt_instance, o_last} !== {1'b1, (i == 0), 1'b1, (i == 2)}) begin
            n_err++;
            $display("FAIL wrap[%0d]: cb=%h want %h flags=%b", i, o_cb, exp_cb[i], {o_valid, o_new_instance, o_pt_instance, o_last});
         end
      end
      i_data_valid = 1'b0;
      n_cmp++;
      if (o_instance_size !== {64'h0, 64'h180}) begin
         n_err++;
         $display("FAIL wrap_size: got %h want %h", o_instance_size, {64'h0, 64'h180});
      end
      tick();
   endtask

   task automatic test_zero_length();
      logic [0:127] jb, pb;
      jb = 128'h0BADF00D_0BADF00D_0BADF00D_00000041;
      pb = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
      i_j0 = 128'h12345678_9ABCDEF0_0F1E2D3C_00000005;
      i_aad_blocks = 16'd0; i_pt_blocks = 16'd0; i_hdr_valid = 1'b1;
      i_data_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1101 ||
          {o_plain_text, o_aad, o_instance_size} !== 384'd0 || o_hdr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL zero_beat: flags=%b hdr_ready=%b size=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_hdr_ready, o_instance_size);
      end
      n_cmp++;
      if (o_j0 !== 128'h12345678_9ABCDEF0_0F1E2D3C_00000005) begin
         n_err++;
         $display("FAIL zero_j0: got %h", o_j0);
      end
      i_j0 = jb; i_aad_blocks = 16'd0; i_pt_blocks = 16'd1;
      tick();
      i_hdr_valid = 1'b0;
      n_cmp++;
      if ({o_valid, o_hdr_ready, o_data_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL zero_second_hdr: got %b want 001", {o_valid, o_hdr_ready, o_data_ready});
      end
      i_data_valid = 1'b1; i_data = pb;
      tick();
      i_data_valid = 1'b0;
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1111 || o_plain_text !== pb ||
          o_cb !== 128'h0BADF00D_0BADF00D_0BADF00D_00000042) begin
         n_err++;
         $display("FAIL zero_next_beat: flags=%b cb=%h pt=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_cb, o_plain_text);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [0:127] p0, ad;
      p0 = 128'hDEADBEEF_00000000_11111111_22222222;
      ad = 128'h99999999_88888888_77777777_66666666;
      i_j0 = 128'h11111111_22222222_33333333_00000010;
      i_aad_blocks = 16'd0; i_pt_blocks = 16'd3; i_hdr_valid = 1'b1;
      tick();
      i_hdr_valid = 1'b0;
      i_data_valid = 1'b1; i_data = p0;
      tick();
      // Early header for the next instance while the data input stalls.
      i_data_valid = 1'b0;
      i_hdr_valid = 1'b1;
      i_j0 = 128'h44444444_55555555_66666666_00000020;
      i_aad_blocks = 16'd1; i_pt_blocks = 16'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({o_valid, o_hdr_ready} !== 2'b00 || o_plain_text !== p0 ||
             o_cb !== 128'h11111111_22222222_33333333_00000011 || o_new_instance !== 1'b1) begin
            n_err++;
            $display("FAIL stall[%0d]: valid=%b hdr_ready=%b cb=%h pt=%h new=%b", i, o_valid, o_hdr_ready, o_cb, o_plain_text, o_new_instance);
         end
      end
      i_data_valid = 1'b1; i_data = 128'd1;
      tick();
      n_cmp++;
      if ({o_valid, o_hdr_ready, o_last} !== 3'b100 || o_cb !== 128'h11111111_22222222_33333333_00000012) begin
         n_err++;
         $display("FAIL stall_resume: valid=%b hdr_ready=%b last=%b cb=%h", o_valid, o_hdr_ready, o_last, o_cb);
      end
      i_data = 128'd2;
      tick();
      n_cmp++;
      if ({o_valid, o_last, o_hdr_ready} !== 3'b111 || o_cb !== 128'h11111111_22222222_33333333_00000013) begin
         n_err++;
         $display("FAIL stall_last: valid=%b last=%b hdr_ready=%b cb=%h", o_valid, o_last, o_hdr_ready, o_cb);
      end
      // Data stays offered across the header cycle; it must not be taken there.
      i_data = ad;
      tick();
      i_hdr_valid = 1'b0;
      n_cmp++;
      if ({o_valid, o_hdr_ready, o_data_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL b2b_hdr: got %b want 001", {o_valid, o_hdr_ready, o_data_ready});
      end
      tick();
      i_data_valid = 1'b0;
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1101 || o_aad !== ad ||
          o_cb !== 128'h44444444_55555555_66666666_00000021 || o_instance_size !== {64'h80, 64'h0}) begin
         n_err++;
         $display("FAIL b2b_beat: flags=%b aad=%h cb=%h size=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_aad, o_cb, o_instance_size);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      i_j0 = 128'h0F0E0D0C_0B0A0908_07060504_7FFFFFFF;
      i_aad_blocks = 16'd0; i_pt_blocks = 16'd4; i_hdr_valid = 1'b1;
      tick();
      i_hdr_valid = 1'b0;
      i_data_valid = 1'b1; i_data = 128'hABCDEF;
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || o_cb !== 128'h0F0E0D0C_0B0A0908_07060504_80000000) begin
         n_err++;
         $display("FAIL mid_first: valid=%b cb=%h", o_valid, o_cb);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last, o_hdr_ready, o_data_ready} !== 6'b000010 ||
          {o_plain_text, o_aad, o_j0, o_cb, o_instance_size} !== 640'd0) begin
         n_err++;
         $display("FAIL mid_async_clear: ctrl=%b cb=%h", {o_valid, o_new_instance, o_pt_instance, o_last, o_hdr_ready, o_data_ready}, o_cb);
      end
      tick();
      rst_n = 1'b1;
      i_data_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_valid, o_last, o_hdr_ready, o_data_ready} !== 4'b0010) begin
         n_err++;
         $display("FAIL mid_after: got %b want 0010", {o_valid, o_last, o_hdr_ready, o_data_ready});
      end
      i_j0 = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_00000000;
      i_aad_blocks = 16'd0; i_pt_blocks = 16'd1; i_hdr_valid = 1'b1;
      tick();
      i_hdr_valid = 1'b0;
      i_data_valid = 1'b1; i_data = 128'h77;
      tick();
      i_data_valid = 1'b0;
      n_cmp++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1111 ||
          o_cb !== 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_00000001 || o_instance_size !== {64'h0, 64'h80}) begin
         n_err++;
         $display("FAIL mid_new_inst: flags=%b cb=%h size=%h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_cb, o_instance_size);
      end
      tick();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_zero_length();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_aes_gcm_instance_feeder
`default_nettype wire
